rx_byte_fifo: RTL and testbench
===============================

Name: rx_byte_fifo

Overview:
Byte buffer between the UART receiver and the RAM word packer (storeByte). It captures each completed receiver byte on the falling edge of the receiver's busy flag and queues it. It then presents the bytes to the downstream consumer over a valid/ready handshake. This decouples RAM write timing from line timing and records overflow when the consumer stalls.

Parameters:
depth, 16, number of byte entries; must be a power of two, at least 2.
addrBits, 4, pointer width; must equal log2(depth).

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
busyRX  input  1  receiver busy flag; a 1->0 transition marks a completed byte.
byteRX  input  8  receiver data; valid in the cycle busyRX is first seen low.
flush  input  1  synchronous clear of the queue contents; statistics are kept.
outValid  output  1  head entry available.
outReady  input  1  consumer accepts the head entry this cycle.
outByte  output  8  head entry data.
count  output  addrBits+1  number of entries held (0..depth).
full  output  1  count == depth.
empty  output  1  count == 0.
overflow  output  1  sticky; a byte arrived while the queue was full.
dropCount  output  16  number of bytes dropped, saturating at 16'hFFFF.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. On reset:
  - read pointer, write pointer, count = 0;
  - empty = 1, full = 0, outValid = 0, outByte = 8'h00;
  - overflow = 0, dropCount = 0;
  - busy history register = 0.
- Edge detect:
  - busyPrev is registered from busyRX every cycle.
  - wrReq = busyPrev & ~busyRX, a single-cycle pulse per byte.
  - byteRX is sampled in the wrReq cycle.
  - busyRX is synchronous to clk; this block adds no synchroniser.
- Write (wrReq & ~full): store at the write pointer; write pointer increments modulo depth.
- Read (outValid & outReady): read pointer increments modulo depth.
- Ready handling:
  - outReady while outValid = 0 has no effect.
  - outReady may be held high continuously.
- Output data:
  - outByte always equals the entry at the read pointer; it is combinational from the registered array and pointer.
  - outValid = ~empty.
  - Latency: a byte written in cycle N is visible on outByte/outValid in cycle N+1.
- Count update:
  - write only: +1;
  - read only: -1;
  - both: unchanged;
  - neither: unchanged.
- Simultaneous write and read when full: the read frees a slot in the same cycle, so the write is accepted, with no drop and no overflow.
- Write when full without a read:
  - the byte is discarded;
  - overflow is set to 1 and stays set until rst;
  - dropCount increments, saturating at 16'hFFFF.
- Simultaneous write and read when empty: the read is ignored because outValid = 0; the write is accepted and count becomes 1.
- flush = 1:
  - next cycle: pointers and count = 0, empty = 1;
  - any wrReq or read in that same cycle is ignored; it is not counted as a drop;
  - overflow and dropCount are unchanged.
- Priority: rst > flush > normal operation.
- full and empty are derived from count, never from pointer equality alone.
- Reset mid-operation: all queued bytes are lost. A busyRX falling edge in the reset cycle is not captured, because busyPrev is forced to 0.
- Wrap-around: the pointers wrap naturally at depth. Entry order is strictly FIFO across the wrap.

Test Plan:
1. Reset then idle:
   - stimulus: rst high for 2 cycles, busyRX = 0;
   - response: empty = 1, full = 0, count = 0, outValid = 0, overflow = 0, dropCount = 0.
2. Single byte:
   - stimulus: busyRX high 10 cycles then low, with byteRX = 8'hA5; outReady = 0;
   - response: the next cycle shows outValid = 1, outByte = 8'hA5, count = 1;
   - then pulse outReady for 1 cycle: empty = 1, count = 0.
3. Fill and overflow:
   - stimulus: 17 busy pulses with bytes 8'h00..8'h10, outReady = 0;
   - response: after 16 pulses full = 1 and count = 16; after the 17th, overflow = 1 and dropCount = 1;
   - drain: 8'h00..8'h0F in order, with 8'h10 absent.
4. Full with simultaneous read:
   - stimulus: queue full; outReady = 1 in the same cycle as wrReq carrying 8'h5A;
   - response: count stays 16, overflow = 0, and 8'h5A is the last byte drained.
5. Wrap-around streaming:
   - stimulus: 40 bytes 8'h20..8'h47, with outReady toggling 1/0 every cycle;
   - response: all 40 bytes are received in order, with no overflow.
6. Flush and reset mid-stream:
   - stimulus: 5 bytes queued, then flush for 1 cycle;
   - response: empty = 1, while overflow and dropCount hold their prior values;
   - then queue 3 bytes and assert rst: count = 0 and dropCount = 0.

Source files
------------

// File: rtl/rx_byte_fifo.sv
// Byte queue between the UART receiver and the RAM word packer.
// Captures a byte on each busyRX falling edge and hands it out over valid/ready.
module rx_byte_fifo #(
    parameter int depth    = 16,
    parameter int addrBits = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                busyRX,
    input  logic [7:0]          byteRX,
    input  logic                flush,
    output logic                outValid,
    input  logic                outReady,
    output logic [7:0]          outByte,
    output logic [addrBits:0]   count,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic [15:0]         dropCount
);

    localparam logic [addrBits:0] DEPTH_CNT = (addrBits+1)'(depth);

    logic [7:0]          mem_q [depth];
    logic [7:0]          mem_d [depth];
    logic [addrBits-1:0] wr_ptr_q, wr_ptr_d;
    logic [addrBits-1:0] rd_ptr_q, rd_ptr_d;
    logic [addrBits:0]   count_q, count_d;
    logic                busy_prev_q, busy_prev_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic wr_req, rd_fire, wr_fire, drop;

    assign count     = count_q;
    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign outValid  = ~empty;
    assign outByte   = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign dropCount = drop_cnt_q;

    always_comb begin
        wr_req  = busy_prev_q & ~busyRX;
        rd_fire = outValid & outReady;
        // A read in the same cycle frees the slot, so a write into a full queue still lands.
        wr_fire = wr_req & (~full | rd_fire);
        drop    = wr_req & full & ~rd_fire;

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        busy_prev_d = busyRX;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) begin
                mem_d[wr_ptr_q] = byteRX;
                wr_ptr_d        = wr_ptr_q + addrBits'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + addrBits'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + (addrBits+1)'(1);
                2'b01:   count_d = count_q - (addrBits+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q       <= '{default: 8'h00};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_prev_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_prev_q <= busy_prev_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboard bench for rx_byte_fifo: stimulus queues expected bytes, a negedge monitor checks handshakes.
module tb_rx_byte_fifo;

    logic        clk = 1'b0;
    logic        rst, busyRX, flush, outReady;
    logic [7:0]  byteRX;
    logic        outValid, full, empty, overflow;
    logic [7:0]  outByte;
    logic [4:0]  count;
    logic [15:0] dropCount;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    rx_byte_fifo #(.depth(16), .addrBits(4)) dut (
        .clk(clk), .rst(rst), .busyRX(busyRX), .byteRX(byteRX), .flush(flush),
        .outValid(outValid), .outReady(outReady), .outByte(outByte),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .dropCount(dropCount)
    );

    // Monitor: a handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!rst && !flush && outValid && outReady) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out: got %02h, required no output", outByte);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (outByte !== e) begin
                    miscompares++;
                    $display("FAIL out_byte: got %02h, required %02h", outByte, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // busyRX high for hi cycles, then low with the byte; returns one cycle after capture.
    task automatic send(input logic [7:0] b, input int hi, input bit accept,
                        input bit rdy_at_edge, input bit flush_at_edge);
        busyRX = 1'b1;
        byteRX = 8'hEE;
        repeat (hi) tick();
        busyRX = 1'b0;
        byteRX = b;
        if (accept) sb.push_back(b);
        if (rdy_at_edge) outReady = 1'b1;
        if (flush_at_edge) flush = 1'b1;
        tick();
        if (rdy_at_edge) outReady = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        outReady = 1'b1;
        while (!empty && n < 100) begin
            tick();
            n++;
        end
        outReady = 1'b0;
        chk("drain_timeout", (n < 100) ? 1 : 0, 1);
        chk("sb_empty_after_drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        busyRX = 1'b0; byteRX = 8'h00; flush = 1'b0; outReady = 1'b0; rst = 1'b0;

        // 1: reset then idle
        do_reset();
        tick();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", outValid, 0);
        chk("rst_outbyte", outByte, 8'h00);
        chk("rst_overflow", overflow, 0);
        chk("rst_dropcount", dropCount, 0);

        // 2: single byte, one-cycle latency, then one read
        send(8'hA5, 10, 1, 0, 0);
        chk("single_valid", outValid, 1);
        chk("single_byte", outByte, 8'hA5);
        chk("single_count", count, 1);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("single_empty", empty, 1);
        chk("single_count0", count, 0);

        // 3: fill across the wrap point, then overflow on the 17th byte
        for (int i = 0; i < 16; i++) send(8'(i), 2, 1, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_no_ovf", overflow, 0);
        send(8'h10, 2, 0, 0, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", dropCount, 1);
        chk("ovf_count", count, 16);
        drain();

        // 4: full queue, write and read in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 2, 1, 0, 0);
        chk("full4", full, 1);
        send(8'h5A, 2, 1, 1, 0);
        chk("simul_count", count, 16);
        chk("simul_ovf", overflow, 0);
        chk("simul_drop", dropCount, 0);
        drain();

        // 5: streaming with outReady toggling every cycle
        begin
            bit done;
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 40; i++) send(8'h20 + 8'(i), 2, 1, 0, 0);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        outReady = ~outReady;
                        tick();
                    end
                end
            join
        end
        drain();
        chk("stream_ovf", overflow, 0);
        chk("stream_drop", dropCount, 0);

        // 6: build up drops, then flush with a coincident byte, then reset
        for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 1, 1, 0, 0);
        send(8'h70, 1, 0, 0, 0);
        send(8'h71, 1, 0, 0, 0);
        chk("pre_flush_drop", dropCount, 2);
        drain();
        for (int i = 0; i < 5; i++) send(8'h80 + 8'(i), 1, 0, 0, 0);
        chk("pre_flush_count", count, 5);
        send(8'h77, 1, 0, 0, 1);
        chk("flush_empty", empty, 1);
        chk("flush_count", count, 0);
        chk("flush_ovf_kept", overflow, 1);
        chk("flush_drop_kept", dropCount, 2);
        for (int i = 0; i < 3; i++) send(8'h90 + 8'(i), 1, 0, 0, 0);
        chk("pre_rst_count", count, 3);
        busyRX = 1'b1;
        tick();
        busyRX = 1'b0;
        byteRX = 8'hCC;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_count", count, 0);
        chk("rst_mid_drop", dropCount, 0);
        chk("rst_mid_ovf", overflow, 0);
        chk("rst_edge_not_captured", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
